counter_mod_updown: RTL and testbench

Parametrised modulo up/down counter; the next-generation replacement for the fixed 4-bit, mod-16, up-only board counter. It adds generic width and modulus, run-time direction, synchronous parallel load, a wrap/saturate mode select, and terminal-count and wrap indications. It sits directly behind the board-level reset inverter and drives the board's display and status logic.

---
 rtl/counter_pkg.sv | 27 ++
 rtl/counter_prescaler.sv | 41 ++++
 rtl/counter_mod_updown.sv | 98 +++++++++
 tb/tb_counter_mod_updown.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family:
// legal parameter ranges, direction encoding and a constant clog2.
package counter_pkg;

  localparam int     WIDTH_MIN    = 1;
  localparam int     WIDTH_MAX    = 32;
  localparam longint MODULUS_MIN  = 2;
  localparam int     PRESCALE_MIN = 1;
  localparam int     PRESCALE_MAX = 65536;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input longint value);
    int     bits;
    longint rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: counts enabled cycles and flags every PRESCALE-th one.
// Only instantiated when COUNTER_MOD_PRESCALE_EN is defined.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  assign tick_o = (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clear_i) begin
      phase_d = '0;
    end else if (enable_i) begin
      phase_d = tick_o ? '0 : phase_q + ONE;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/counter_mod_updown.sv
// Parametrised modulo up/down counter with load, wrap/saturate mode and
// terminal/wrap flags. Optional clock-enable prescaler: COUNTER_MOD_PRESCALE_EN.
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             up_i,
  input  logic             saturate_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] counter_value_o,
  output logic             terminal_o,
  output logic             wrap_o
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("counter_mod_updown: WIDTH out of range");
  end
  if (MODULUS < MODULUS_MIN || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("counter_mod_updown: MODULUS out of range");
  end
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("counter_mod_updown: PRESCALE out of range");
  end

  // MODULUS-1 always fits in WIDTH bits, so a full-range modulus needs no
  // extra carry bit and "load >= MODULUS" becomes "load > MAX_VAL".
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             tick;
  logic             step;

`ifdef COUNTER_MOD_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .clear_i  (load_i),
    .tick_o   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign step = enable_i & tick;

  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      value_d = (load_value_i > MAX_VAL) ? MAX_VAL : load_value_i;
    end else if (step) begin
      if (up_i == DIR_UP) begin
        if (value_q != MAX_VAL) begin
          value_d = value_q + ONE;
        end else if (!saturate_i) begin
          value_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (value_q != '0) begin
          value_d = value_q - ONE;
        end else if (!saturate_i) begin
          value_d = MAX_VAL;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  assign counter_value_o = value_q;
  assign wrap_o          = wrap_q;
  assign terminal_o      = (up_i == DIR_UP) ? (value_q == MAX_VAL) : (value_q == '0);

endmodule

// File: tb/tb_counter_mod_updown.sv
// Randomised and directed check of counter_mod_updown (MODULUS=10 and
// full-range MODULUS=8) against an integer reference model.
module tb_counter_mod_updown;

`ifdef COUNTER_MOD_PRESCALE_EN
  localparam int PRESC = 3;
`else
  localparam int PRESC = 1;
`endif
  localparam int MODS [2] = '{10, 8};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       sat;
  logic       ld;
  logic [3:0] lv;
  logic [2:0] lv3;
  logic [3:0] q0;
  logic [2:0] q1;
  logic       t0, t1, w0, w1;

  int n_tests = 0;
  int n_fail  = 0;
  int mv  [2];
  int mw  [2];
  int mph [2];

  assign lv3 = lv[2:0];

  always #5 clk = ~clk;

  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .PRESCALE(PRESC)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .up_i(up), .saturate_i(sat),
    .load_i(ld), .load_value_i(lv), .counter_value_o(q0), .terminal_o(t0), .wrap_o(w0)
  );

  counter_mod_updown #(.WIDTH(3), .MODULUS(8), .PRESCALE(PRESC)) dut8 (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .up_i(up), .saturate_i(sat),
    .load_i(ld), .load_value_i(lv3), .counter_value_o(q1), .terminal_o(t1), .wrap_o(w1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; mw[d] = 0; mph[d] = 0;
    end
  endtask

  // Behaviour at one rising edge, from the counting rules in plain integers.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int m;
      int lval;
      bit stp;
      m    = MODS[d];
      lval = (d == 0) ? int'(lv) : int'(lv3);
      stp  = 1'b0;
      mw[d] = 0;
      if (ld) begin
        mv[d]  = (lval >= m) ? m - 1 : lval;
        mph[d] = 0;
      end else begin
        if (en) begin
          if (mph[d] == PRESC - 1) begin
            stp = 1'b1; mph[d] = 0;
          end else begin
            mph[d]++;
          end
        end
        if (stp && up) begin
          if (mv[d] < m - 1) mv[d]++;
          else if (!sat) begin mv[d] = 0; mw[d] = 1; end
        end else if (stp) begin
          if (mv[d] > 0) mv[d]--;
          else if (!sat) begin mv[d] = m - 1; mw[d] = 1; end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/value10"}, int'(q0), mv[0]);
    chk({tag, "/wrap10"},  int'(w0), mw[0]);
    chk({tag, "/term10"},  int'(t0), up ? int'(mv[0] == 9) : int'(mv[0] == 0));
    chk({tag, "/value8"},  int'(q1), mv[1]);
    chk({tag, "/wrap8"},   int'(w1), mw[1]);
    chk({tag, "/term8"},   int'(t1), up ? int'(mv[1] == 7) : int'(mv[1] == 0));
  endtask

  task automatic cyc(input logic e, input logic u, input logic s, input logic l,
                     input logic [3:0] v, input string tag);
    en = e; up = u; sat = s; ld = l; lv = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; sat = 1'b0; ld = 1'b0; lv = '0;
    model_reset();
    #12;
    check_all("reset_down");
    up = 1'b1;
    #1;
    check_all("reset_up");
    @(negedge clk);
    rst = 1'b0;

    repeat (12 * PRESC) cyc(1, 1, 0, 0, 4'd0, "wrap_up");

    cyc(1, 0, 0, 1, 4'd1, "load1");
    repeat (3 * PRESC) cyc(1, 0, 0, 0, 4'd0, "down_wrap");
    cyc(1, 0, 1, 1, 4'd1, "load1_sat");
    repeat (4 * PRESC) cyc(1, 0, 1, 0, 4'd0, "down_sat");

    cyc(1, 1, 0, 1, 4'd13, "clamp");
    cyc(1, 1, 0, 1, 4'd6, "load6");
    repeat (3 * PRESC) cyc(1, 1, 0, 0, 4'd0, "full_range");

    up = 1'b0;
    #1;
    check_all("term_dir");

    repeat (PRESC) cyc(1, 1, 0, 0, 4'd0, "pre_gap");
    repeat (2) cyc(0, 1, 0, 0, 4'd0, "gap");
    repeat (2 * PRESC) cyc(1, 1, 0, 0, 4'd0, "post_gap");

    cyc(1, 1, 0, 1, 4'd5, "load5");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * PRESC) cyc(1, 1, 0, 0, 4'd0, "after_rst");

    repeat (400) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
